// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter/controller
//
// Purpose : FSM state type, default bus widths and statistics counter widths
//           used by sram_arbiter_ctrl.
// Ports   : none (package).
package sram_arb_pkg;

  localparam int AW_DEF        = 20;
  localparam int DW_DEF        = 16;
  localparam int STAT_CNT_W    = 32;
  localparam int STAT_STARVE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    WR_HOLD = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter_ctrl.sv
// rtl/sram_arbiter_ctrl.sv - two-port arbiter and timing controller for the async 16-bit SRAM
//
// Purpose : Serialises a read port (VGA prefetch) and a write port (pixel writes)
//           onto one asynchronous SRAM bus. Every SRAM pin, including the DQ
//           output enable, comes straight from a register.
// Ports   : sys_clk/sys_rst          - clock, async active-high reset
//           rd_req/rd_addr/rd_ready  - read request handshake
//           rd_rvalid/rd_rdata       - read data pulse and held data
//           wr_req/wr_addr/wr_data/wr_be/wr_ready - write request handshake
//           sram_addr/sram_dq/sram_ce_n/sram_oe_n/sram_we_n/sram_be_n - SRAM pins
//           stat_rd_cnt/stat_wr_cnt/stat_starve_cnt - grant counters, only when
//           SRAM_ARB_STATS_EN is defined
// Macro   : SRAM_ARB_STATS_EN enables the statistics counters and their ports.
module sram_arbiter_ctrl
  import sram_arb_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int RD_CYCLES     = 2,
  parameter int WR_CYCLES     = 2,
  parameter int WR_STARVE_MAX = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic                     rd_ready,
  output logic                     rd_rvalid,
  output logic [DW-1:0]            rd_rdata,
  input  logic                     wr_req,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [1:0]               wr_be,
  output logic                     wr_ready,
  output logic [AW-1:0]            sram_addr,
  inout  wire  [DW-1:0]            sram_dq,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
`ifdef SRAM_ARB_STATS_EN
  output logic [1:0]               sram_be_n,
  output logic [STAT_CNT_W-1:0]    stat_rd_cnt,
  output logic [STAT_CNT_W-1:0]    stat_wr_cnt,
  output logic [STAT_STARVE_W-1:0] stat_starve_cnt
`else
  output logic [1:0]               sram_be_n
`endif
);

  localparam int PH_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int SW     = $clog2(WR_STARVE_MAX + 1);

  arb_state_t      state;
  logic [PW-1:0]   phase;
  logic [SW-1:0]   starve_cnt;
  logic [DW-1:0]   dq_out;
  logic            dq_oe;
  logic            write_pri;
  logic            grant_rd;
  logic            grant_wr;

  // Tri-state driver; the enable is a flop so the pins never see a glitch.
  assign sram_dq = dq_oe ? dq_out : {DW{1'bz}};

  // Grants are combinational in IDLE only. Reset is folded in so both
  // ready outputs read 0 while sys_rst is high.
  always_comb begin
    write_pri = (starve_cnt == SW'(WR_STARVE_MAX));
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (!sys_rst && state == IDLE) begin
      grant_wr = wr_req && (!rd_req || write_pri);
      grant_rd = rd_req && !grant_wr;
    end
  end

  assign rd_ready = grant_rd;
  assign wr_ready = grant_wr;

  // Counts read grants taken while a write waits; cleared once the write
  // side is served or stops asking.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      starve_cnt <= '0;
    end else if (grant_wr || !wr_req) begin
      starve_cnt <= '0;
    end else if (grant_rd && !write_pri) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      phase     <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= 2'b11;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      rd_rvalid <= 1'b0;
      rd_rdata  <= '0;
    end else begin
      rd_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          phase <= '0;
          if (grant_rd) begin
            state     <= READ;
            sram_addr <= rd_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_be_n <= 2'b00;
          end else if (grant_wr) begin
            state     <= WRITE;
            sram_addr <= wr_addr;
            dq_out    <= wr_data;
            dq_oe     <= 1'b1;
            sram_ce_n <= 1'b0;
            sram_we_n <= 1'b0;
            sram_be_n <= ~wr_be;
          end
        end
        READ: begin
          if (phase == PW'(RD_CYCLES - 1)) begin
            rd_rdata  <= sram_dq;
            rd_rvalid <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= 2'b11;
            phase     <= '0;
            state     <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        WRITE: begin
          if (phase == PW'(WR_CYCLES - 1)) begin
            sram_we_n <= 1'b1;
            phase     <= '0;
            state     <= WR_HOLD;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        WR_HOLD: begin
          // Data and address were held one cycle past the WE rising edge.
          sram_ce_n <= 1'b1;
          sram_be_n <= 2'b11;
          dq_oe     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // A write granted while a read is also pending can only have been forced
  // by the starve limit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_rd_cnt     <= '0;
      stat_wr_cnt     <= '0;
      stat_starve_cnt <= '0;
    end else begin
      if (grant_rd) stat_rd_cnt <= stat_rd_cnt + 1'b1;
      if (grant_wr) stat_wr_cnt <= stat_wr_cnt + 1'b1;
      if (grant_wr && rd_req) stat_starve_cnt <= stat_starve_cnt + 1'b1;
    end
  end
`endif

endmodule
